// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester handshakes and the SRAM pin-side signals
// for the sram_arbiter. The arbiter uses the slave modport. The master
// modport is the view of the requesters and of the SRAM model.
interface sram_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [7:0]        m0_wdata;
  logic              m0_ack;
  logic [7:0]        m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [7:0]        m1_wdata;
  logic              m1_ack;
  logic [7:0]        m1_rdata;

  logic [ADDR_W-1:0] sram_addr_o;
  logic [7:0]        sram_data_o;
  logic              sram_data_oe;
  logic [7:0]        sram_data_i;
  logic              sram_we_n;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  sram_data_i,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output sram_addr_o, sram_data_o, sram_data_oe, sram_we_n, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output sram_data_i,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  sram_addr_o, sram_data_o, sram_data_oe, sram_we_n, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single external 8-bit asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYC cycles) -> DONE.
// Address, write data and the write-enable flag are latched at grant. The
// ack is a one-cycle pulse in DONE.
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration.
// Without it, requester 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int ACCESS_CYC = 2     // legal range 1..15
) (
  input logic       clk,
  input logic       reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              gnt;          // requester that owns the current access
  logic              last_grant;
  logic              cur_we;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              oe_q;
  logic              we_n_q;
  logic [1:0]        ack_q;
  logic [1:0][7:0]   rdata_q;

  logic [1:0]        req;
  logic              gnt_sel;

  assign req = {bus.m1_req, bus.m0_req};

  // Choose the winner among the active requests in IDLE.
  always_comb begin
    gnt_sel = 1'b0;
`ifdef SRAM_ARB_RR_EN
    // On contention, the requester that did not win last time is granted.
    gnt_sel = (&req) ? ~last_grant : req[1];
`else
    gnt_sel = ~req[0];
`endif
  end

  // Access sequencer. All SRAM pins and acks are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      cur_we     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      oe_q       <= 1'b0;
      we_n_q     <= 1'b1;
      ack_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= gnt_sel;
            last_grant <= gnt_sel;
            addr_q     <= gnt_sel ? bus.m1_addr  : bus.m0_addr;
            data_q     <= gnt_sel ? bus.m1_wdata : bus.m0_wdata;
            cur_we     <= gnt_sel ? bus.m1_we    : bus.m0_we;
            oe_q       <= gnt_sel ? bus.m1_we    : bus.m0_we;
            state      <= SETUP;
          end
        end
        SETUP: begin
          cnt    <= '0;
          we_n_q <= ~cur_we;
          state  <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'(ACCESS_CYC - 1)) begin
            we_n_q     <= 1'b1;
            ack_q[gnt] <= 1'b1;
            if (!cur_we) rdata_q[gnt] <= bus.sram_data_i;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          // Address and data stay held through DONE to give the SRAM hold time.
          ack_q <= '0;
          oe_q  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_data_o  = data_q;
  assign bus.sram_data_oe = oe_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.m0_ack       = ack_q[0];
  assign bus.m1_ack       = ack_q[1];
  assign bus.m0_rdata     = rdata_q[0];
  assign bus.m1_rdata     = rdata_q[1];
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a behavioural SRAM, a scoreboard of
// expected completions, table-driven single accesses, and hand sequences
// for contention, a dropped request and reset during a write.
module tb_sram_arbiter;
  localparam int AW = 21;
  localparam int AC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) bus();
  sram_arbiter #(.ADDR_W(AW), .ACCESS_CYC(AC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural SRAM. Unwritten locations read as low address byte ^ 0x3C.
  logic [7:0] mem [int];
  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ 8'h3C;
  endfunction

  // The model updates away from the DUT clock edge.
  always @(negedge clk) begin
    if (!bus.sram_we_n && bus.sram_data_oe) mem[int'(bus.sram_addr_o)] = bus.sram_data_o;
    bus.sram_data_i = mem_rd(bus.sram_addr_o);
  end

  // Scoreboard of expected completions, popped on every ack.
  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.m0_ack || bus.m1_ack) begin
        chk("ack_onehot", {31'd0, bus.m0_ack & bus.m1_ack}, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("ack_id", {31'd0, bus.m1_ack}, {31'd0, e.id});
          chk("done_addr", 32'(bus.sram_addr_o), 32'(e.addr));
          chk("done_we_n", {31'd0, bus.sram_we_n}, 1);
          if (e.we) begin
            chk("done_wdata", 32'(bus.sram_data_o), 32'(e.data));
            chk("mem_write", 32'(mem_rd(e.addr)), 32'(e.data));
          end else begin
            chk("rdata", 32'(e.id ? bus.m1_rdata : bus.m0_rdata), 32'(e.data));
          end
        end
      end
      if (!bus.sram_we_n) chk("we_n_low_idle", {31'd0, bus.busy}, 1);
    end
  end

  task automatic set_req(input bit id, input bit v);
    if (id) bus.m1_req = v; else bus.m0_req = v;
  endtask

  // One access from a single requester, with cycle-by-cycle checks.
  // A drop_after value of -1 means "drop req after ack". Any other value n
  // drops req at the start of cycle n+1.
  task automatic run_one(input bit id, input bit we, input logic [AW-1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_data,
                         input int drop_after);
    exp_t e;
    int ack_cyc, ack_n;
    logic [15:0] we_mask, oe_mask, exp_we, exp_oe;
    logic [7:0] prev0, prev1;
    e.id = id; e.we = we; e.addr = addr; e.data = we ? wdata : exp_data;
    sbq.push_back(e);
    prev0 = bus.m0_rdata; prev1 = bus.m1_rdata;
    ack_cyc = -1; ack_n = 0; we_mask = '0; oe_mask = '0;
    @(posedge clk); #1;
    if (id) begin
      bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
    set_req(id, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) begin
        ack_n++;
        if (ack_cyc < 0) ack_cyc = c;
      end
      we_mask[c] = ~bus.sram_we_n;
      oe_mask[c] = bus.sram_data_oe;
      if (c == 0) chk("idle_busy", {31'd0, bus.busy}, 0);
      if (c == 1) begin
        chk("setup_addr", 32'(bus.sram_addr_o), 32'(addr));
        chk("setup_busy", {31'd0, bus.busy}, 1);
        if (we) chk("setup_wdata", 32'(bus.sram_data_o), 32'(wdata));
      end
      if (c == AC + 3) chk("post_busy", {31'd0, bus.busy}, 0);
      @(posedge clk); #1;
      if (c == 0) begin
        // Inputs change after the grant. The access must not see them.
        if (id) begin bus.m1_addr = ~addr; bus.m1_wdata = ~wdata; end
        else    begin bus.m0_addr = ~addr; bus.m0_wdata = ~wdata; end
      end
      if (c == drop_after || (drop_after < 0 && ack_cyc == c)) set_req(id, 1'b0);
    end
    exp_we = we ? 16'(((1 << AC) - 1) << 2) : 16'd0;
    exp_oe = we ? 16'(((1 << (AC + 2)) - 1) << 1) : 16'd0;
    chk("ack_cycle", 32'(ack_cyc), 32'(AC + 2));
    chk("ack_count", 32'(ack_n), 1);
    chk("we_n_mask", 32'(we_mask), 32'(exp_we));
    chk("oe_mask", 32'(oe_mask), 32'(exp_oe));
    chk("sb_empty", 32'(sbq.size()), 0);
    if (id) chk("other_rdata", 32'(bus.m0_rdata), 32'(prev0));
    else    chk("other_rdata", 32'(bus.m1_rdata), 32'(prev1));
    if (we) chk("own_rdata_write", 32'(id ? bus.m1_rdata : bus.m0_rdata), 32'(id ? prev1 : prev0));
  endtask

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    exp;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int n0, n1, last_t, acks;
    exp_t e;
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, last_t, acks;
    exp_t e;
    bit order [6];
    reset = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.sram_data_i = '0;
    mem[int'(21'h1ABCD)] = 8'h5A;

    vecs[0] = '{1'b0, 1'b0, 21'h1ABCD, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 21'h00010, 8'hC3, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 21'h00010, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 21'h1FFFFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 21'h00000, 8'h00, 8'h3C};
    vecs[6] = '{1'b0, 1'b1, 21'h00000, 8'h00, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 21'h00000, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we_n", {31'd0, bus.sram_we_n}, 1);
    chk("rst_oe", {31'd0, bus.sram_data_oe}, 0);
    chk("rst_addr", 32'(bus.sram_addr_o), 0);
    chk("rst_data", 32'(bus.sram_data_o), 0);
    chk("rst_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 0);
    chk("rst_rdata", {16'd0, bus.m1_rdata, bus.m0_rdata}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contention directly after reset: 3 reads from each requester.
`ifdef SRAM_ARB_RR_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 6; i++) begin
      e.id = order[i]; e.we = 1'b0;
      e.addr = order[i] ? 21'h00222 : 21'h00111;
      e.data = order[i] ? 8'h1E : 8'h2D;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.m0_we = 0; bus.m0_addr = 21'h00111;
    bus.m1_we = 0; bus.m1_addr = 21'h00222;
    bus.m0_req = 1; bus.m1_req = 1;
    n0 = 0; n1 = 0; last_t = -1;
    for (int c = 0; c < 60 && (n0 + n1) < 6; c++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) begin
        if (last_t >= 0) chk("contention_spacing", 32'(c - last_t), 32'(AC + 3));
        last_t = c;
      end
      if (bus.m0_ack) n0++;
      if (bus.m1_ack) n1++;
      @(posedge clk); #1;
      if (n0 == 3) bus.m0_req = 0;
      if (n1 == 3) bus.m1_req = 0;
    end
    bus.m0_req = 0; bus.m1_req = 0;
    chk("contention_acks", 32'(n0 + n1), 6);
    chk("contention_sb_empty", 32'(sbq.size()), 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++)
      run_one(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, -1);

    // m1 drops req as SETUP begins. The access must still complete.
    run_one(1'b1, 1'b0, 21'h00333, 8'h00, 8'h0F, 0);

    // Reset during the first ACCESS cycle of a write.
    @(posedge clk); #1;
    bus.m0_we = 1; bus.m0_addr = 21'h00ABC; bus.m0_wdata = 8'h77; bus.m0_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_we_n", {31'd0, bus.sram_we_n}, 0);
    @(posedge clk); #1;
    reset = 1'b0; bus.m0_req = 0; bus.m0_we = 0;
    @(negedge clk);
    chk("abort_we_n", {31'd0, bus.sram_we_n}, 1);
    chk("abort_oe", {31'd0, bus.sram_data_oe}, 0);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_addr", 32'(bus.sram_addr_o), 0);
    chk("abort_rdata", {16'd0, bus.m1_rdata, bus.m0_rdata}, 0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 0);
    run_one(1'b0, 1'b0, 21'h1ABCD, 8'h00, 8'h5A, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
